// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants, FSM state type and slot-write helper for the DCT trace packer.
package nios2_oci_dct_pkg;
  localparam int unsigned SYM_W     = 2;
  localparam int unsigned NUM_SYMS  = 15;
  localparam int unsigned DCT_BUF_W = SYM_W * NUM_SYMS;
  localparam int unsigned DCT_CNT_W = 4;

  typedef enum logic [1:0] {ACCUM, ENDING, ENDED} dct_state_e;

  // Returns buffer b with symbol s written into slot number slot.
  function automatic logic [DCT_BUF_W-1:0] put_sym(input logic [DCT_BUF_W-1:0] b,
                                                   input logic [DCT_CNT_W-1:0] slot,
                                                   input logic [SYM_W-1:0]     s);
    logic [DCT_BUF_W-1:0] r;
    r = b;
    r[int'(slot) * SYM_W +: SYM_W] = s;
    return r;
  endfunction
endpackage

// File: rtl/nios2_oci_dct_hold.sv
// Single-entry valid/ready holding register for completed DCT frames.
module nios2_oci_dct_hold
  import nios2_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DCT_BUF_W-1:0] push_data,
  input  logic [DCT_CNT_W-1:0] push_count,
  input  logic                 frame_ready,
  output logic                 frame_valid,
  output logic [DCT_BUF_W-1:0] frame_data,
  output logic [DCT_CNT_W-1:0] frame_count,
  output logic                 hold_free
);
  logic                 valid_q, valid_d;
  logic [DCT_BUF_W-1:0] data_q, data_d;
  logic [DCT_CNT_W-1:0] count_q, count_d;

  assign hold_free   = !valid_q || frame_ready;
  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign frame_count = count_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
      count_d = push_count;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
      data_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/nios2_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit DCT trace symbols into 15-slot frames, handles flush, drops and end-of-test drain.
module nios2_nios2_qsys_oci_dct_packer
  import nios2_oci_dct_pkg::*;
#(
  parameter int unsigned DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_valid,
  input  logic [SYM_W-1:0]     sym,
  input  logic                 flush,
  input  logic                 test_ending,
  input  logic                 frame_ready,
  output logic                 frame_valid,
  output logic [DCT_BUF_W-1:0] frame_data,
  output logic [DCT_CNT_W-1:0] frame_count,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 test_has_ended
);
  localparam logic [DCT_CNT_W-1:0] FULL = DCT_CNT_W'(NUM_SYMS);

  dct_state_e           state_q, state_d;
  logic [DCT_BUF_W-1:0] acc_q, acc_d, acc_app;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d, cnt_app;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 flush_pend_q, flush_pend_d, fp_any;
  logic                 ended_q, ended_d;
  logic                 push, ovf_push, hold_free;
  logic [DCT_BUF_W-1:0] push_data;
  logic [DCT_CNT_W-1:0] push_count;

  nios2_oci_dct_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .push_count (push_count),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .frame_count(frame_count),
    .hold_free  (hold_free)
  );

  always_comb begin
    acc_app    = acc_q;
    cnt_app    = cnt_q;
    drop_d     = drop_q;
    push       = 1'b0;
    ovf_push   = 1'b0;
    push_data  = '0;
    push_count = '0;
    state_d    = state_q;
    ended_d    = ended_q;

    if (sym_valid && state_q == ACCUM) begin
      if (cnt_q != FULL) begin
        acc_app = put_sym(acc_q, cnt_q, sym);
        cnt_app = cnt_q + DCT_CNT_W'(1);
      end else if (hold_free) begin
        push       = 1'b1;
        ovf_push   = 1'b1;
        push_data  = acc_q;
        push_count = cnt_q;
        acc_app    = put_sym('0, '0, sym);
        cnt_app    = DCT_CNT_W'(1);
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end

    // Flush and auto-push look at the post-append buffer; an overflow push
    // already used the holding register, so a pending flush waits a cycle.
    fp_any       = flush_pend_q || flush || (state_q == ACCUM && test_ending);
    acc_d        = acc_app;
    cnt_d        = cnt_app;
    flush_pend_d = fp_any;
    if (state_q != ENDED && !ovf_push && hold_free && cnt_app != '0 &&
        (cnt_app == FULL || fp_any)) begin
      push         = 1'b1;
      push_data    = acc_app;
      push_count   = cnt_app;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (cnt_app == '0) begin
      flush_pend_d = 1'b0;
    end

    case (state_q)
      ACCUM:  if (test_ending) state_d = ENDING;
      ENDING: if (cnt_q == '0 && !flush_pend_q && hold_free) begin
        state_d = ENDED;
        ended_d = 1'b1;
      end
      default: state_d = ENDED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      drop_q       <= '0;
      flush_pend_q <= 1'b0;
      ended_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      flush_pend_q <= flush_pend_d;
      ended_q      <= ended_d;
    end
  end

  assign dct_buffer     = acc_q;
  assign dct_count      = cnt_q;
  assign drop_count     = drop_q;
  assign test_has_ended = ended_q;
endmodule
